// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI device endpoint.
//   SPI_IDLE_BYTE : byte shifted out when the transmit buffer is empty
//   SPI_BITS      : frame length in bits
//   SPI_CNT_W     : width of the in-frame bit counter
//   spi_state_e   : device FSM state encoding
package spi_pkg;

   localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;
   localparam int         SPI_BITS      = 8;
   localparam int         SPI_CNT_W     = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous pin plus
// rise/fall detection one flop after the last synchronizer stage.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   async_in     : pin from the asynchronous domain
//   rise, fall   : single-cycle strobes for a synchronized edge
// Parameters:
//   SYNC_STAGES  : synchronizer depth (2 or more)
//   RST_VAL      : reset value of the chain, matching the pin's idle level
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   cur;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      cur    = sync_q[SYNC_STAGES-1];
      prev_d = cur;
      rise   = cur & ~prev_q;
      fall   = ~cur & prev_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

endmodule : spi_sync_edge

// File: rtl/spi_dev.sv
// spi_dev: SPI device (slave) endpoint, mode 0, MSB first, 8-bit frames.
// All pins are oversampled in the clk domain (SCK <= clk/8).
// Ports:
//   clk, reset_n        : system clock, async active-low reset
//   sck, ss_n, mosi     : SPI pins from the host (asynchronous)
//   miso, miso_oe       : device data out and its tristate enable
//   tx_data, tx_wr      : local write into the one-deep transmit buffer
//   tx_ready            : transmit buffer empty
//   rx_data, rx_valid   : last received byte and its one-cycle strobe
//   underrun            : strobe, a byte was loaded from an empty buffer
//   busy                : selected (state SHIFT)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not selected; sck events ignored, miso parked at 1
// SHIFT | selected; rx on rising sck, tx on falling sck
module spi_dev
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sck,
   input  logic       ss_n,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       underrun,
   output logic       busy
);

   localparam logic [SPI_CNT_W-1:0] CNT_LAST = SPI_CNT_W'(SPI_BITS - 1);

   logic sck_rise, sck_fall, ss_rise, ss_fall;
   logic mosi_s;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk     (clk),
      .reset_n (reset_n),
      .async_in(sck),
      .rise    (sck_rise),
      .fall    (sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .clk     (clk),
      .reset_n (reset_n),
      .async_in(ss_n),
      .rise    (ss_rise),
      .fall    (ss_fall)
   );

   // mosi only needs a level; no edge detect.
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   end

   spi_state_e           state_q, state_d;
   logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   // Bit 7 of the outgoing byte lives in miso_q; tx_shift holds the rest.
   logic [6:0]           tx_shift_q, tx_shift_d;
   // The newest bit arrives with mosi_s, so only 7 bits need storing.
   logic [6:0]           rx_shift_q, rx_shift_d;
   logic [7:0]           rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 miso_q, miso_d;
   logic [7:0]           buf_q, buf_d;
   logic                 buf_full_q, buf_full_d;
   logic                 underrun_q, underrun_d;
   logic                 load_ev;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      miso_d     = miso_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      underrun_d = 1'b0;
      load_ev    = 1'b0;

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d    = SHIFT;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               load_ev    = 1'b1;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               // Deselect drops any partial frame; a consumed byte is lost.
               state_d    = IDLE;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               tx_shift_d = SPI_IDLE_BYTE[6:0];
               miso_d     = 1'b1;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift_q[5:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_LAST) begin
                  rx_data_d  = {rx_shift_q, mosi_s};
                  rx_valid_d = 1'b1;
               end
            end else if (sck_fall) begin
               if (bit_cnt_q != '0) begin
                  miso_d     = tx_shift_q[6];
                  tx_shift_d = {tx_shift_q[5:0], 1'b1};
               end else begin
                  // Frame just completed: present the next byte's MSB.
                  load_ev = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load_ev) begin
         if (buf_full_q) begin
            miso_d     = buf_q[7];
            tx_shift_d = buf_q[6:0];
            buf_full_d = 1'b0;
         end else begin
            miso_d     = SPI_IDLE_BYTE[7];
            tx_shift_d = SPI_IDLE_BYTE[6:0];
            underrun_d = 1'b1;
         end
      end

      // Gated on the registered flag: a write coinciding with a load from
      // an empty buffer is kept for the following load.
      if (tx_wr && !buf_full_q) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mosi_sync_q <= '0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         tx_shift_q  <= SPI_IDLE_BYTE[6:0];
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         miso_q      <= 1'b1;
         buf_q       <= '0;
         buf_full_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         miso_q      <= miso_d;
         buf_q       <= buf_d;
         buf_full_q  <= buf_full_d;
         underrun_q  <= underrun_d;
      end
   end

   always_comb begin
      miso     = miso_q;
      miso_oe  = (state_q == SHIFT);
      busy     = (state_q == SHIFT);
      tx_ready = ~buf_full_q;
      rx_data  = rx_data_q;
      rx_valid = rx_valid_q;
      underrun = underrun_q;
   end

endmodule : spi_dev

// File: tb/tb_spi_dev.sv
// tb_spi_dev: directed bench for spi_dev; a mode-0 host model clocks SCK
// at clk/8 and samples miso just before each SCK rise.
module tb_spi_dev;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sck;
   logic       ss_n;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       underrun;
   logic       busy;

   int n_assert = 0;
   int n_fail   = 0;
   int rxv_cnt  = 0;
   int urun_cnt = 0;

   spi_dev #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .sck     (sck),
      .ss_n    (ss_n),
      .mosi    (mosi),
      .miso    (miso),
      .miso_oe (miso_oe),
      .tx_data (tx_data),
      .tx_wr   (tx_wr),
      .tx_ready(tx_ready),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .underrun(underrun),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // Counting high cycles makes a delta of 1 mean a single one-cycle pulse.
   always @(negedge clk) begin
      if (rx_valid) rxv_cnt++;
      if (underrun) urun_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic write_buf(input logic [7:0] v);
      tx_data = v;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr   = 1'b0;
   endtask

   // Clock nbits bits MSB first; optionally write wr_val to the buffer
   // during the high phase of the 4th bit.
   task automatic host_bits(input logic [7:0] mo, input int nbits,
                            input logic do_wr, input logic [7:0] wr_val,
                            output logic [7:0] mi);
      mi = 8'h00;
      for (int k = 0; k < nbits; k++) begin
         mosi = mo[7-k];
         repeat (4) @(negedge clk);
         mi[7-k] = miso;
         sck = 1'b1;
         if (do_wr && k == 3) begin
            tx_data = wr_val;
            tx_wr   = 1'b1;
            @(negedge clk);
            tx_wr   = 1'b0;
            repeat (3) @(negedge clk);
         end else begin
            repeat (4) @(negedge clk);
         end
         sck = 1'b0;
      end
   endtask

   task automatic deselect();
      repeat (4) @(negedge clk);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_miso"},     32'(miso),     32'h1);
      check_eq({pfx, "_miso_oe"},  32'(miso_oe),  32'h0);
      check_eq({pfx, "_rx_data"},  32'(rx_data),  32'h0);
      check_eq({pfx, "_rx_valid"}, 32'(rx_valid), 32'h0);
      check_eq({pfx, "_tx_ready"}, 32'(tx_ready), 32'h1);
      check_eq({pfx, "_underrun"}, 32'(underrun), 32'h0);
      check_eq({pfx, "_busy"},     32'(busy),     32'h0);
   endtask

   initial begin
      logic [7:0] mi;
      int r0, u0;

      reset_n = 1'b0;
      sck     = 1'b0;
      ss_n    = 1'b1;
      mosi    = 1'b0;
      tx_wr   = 1'b0;
      tx_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // Buffered byte out, 0x3C in.
      write_buf(8'hA5);
      check_eq("t1_tx_ready_wr", 32'(tx_ready), 32'h0);
      r0 = rxv_cnt;
      u0 = urun_cnt;
      ss_n = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("t1_busy",     32'(busy),     32'h1);
      check_eq("t1_miso_oe",  32'(miso_oe),  32'h1);
      check_eq("t1_tx_ready", 32'(tx_ready), 32'h1);
      check_eq("t1_no_urun",  urun_cnt - u0, 32'h0);
      host_bits(8'h3C, 8, 1'b0, 8'h00, mi);
      repeat (2) @(negedge clk);
      check_eq("t1_host_rd",  32'(mi),       32'hA5);
      check_eq("t1_rx_data",  32'(rx_data),  32'h3C);
      check_eq("t1_rxv_cnt",  rxv_cnt - r0,  32'h1);
      deselect();
      check_eq("t1_busy_off", 32'(busy),     32'h0);
      check_eq("t1_miso_idl", 32'(miso),     32'h1);

      // Empty buffer: 0xFF and one underrun at select.
      u0 = urun_cnt;
      r0 = rxv_cnt;
      ss_n = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("t2_urun_sel", urun_cnt - u0, 32'h1);
      check_eq("t2_miso",     32'(miso),     32'h1);
      host_bits(8'h00, 8, 1'b0, 8'h00, mi);
      check_eq("t2_host_rd",  32'(mi),       32'hFF);
      check_eq("t2_rx_data",  32'(rx_data),  32'h00);
      check_eq("t2_rxv_cnt",  rxv_cnt - r0,  32'h1);
      deselect();

      // Back-to-back bytes, second byte written mid-first-byte.
      write_buf(8'h12);
      r0 = rxv_cnt;
      ss_n = 1'b0;
      host_bits(8'h81, 8, 1'b1, 8'h34, mi);
      check_eq("t3_host_rd0", 32'(mi),       32'h12);
      check_eq("t3_rx_data0", 32'(rx_data),  32'h81);
      host_bits(8'h7E, 8, 1'b0, 8'h00, mi);
      check_eq("t3_host_rd1", 32'(mi),       32'h34);
      check_eq("t3_rx_data1", 32'(rx_data),  32'h7E);
      check_eq("t3_rxv_cnt",  rxv_cnt - r0,  32'h2);
      deselect();

      // Abort after 5 bits, then a full byte must frame from bit 7.
      r0 = rxv_cnt;
      ss_n = 1'b0;
      host_bits(8'hF0, 5, 1'b0, 8'h00, mi);
      deselect();
      check_eq("t4_rxv_cnt",  rxv_cnt - r0,  32'h0);
      check_eq("t4_busy",     32'(busy),     32'h0);
      check_eq("t4_miso",     32'(miso),     32'h1);
      check_eq("t4_miso_oe",  32'(miso_oe),  32'h0);
      check_eq("t4_rx_keep",  32'(rx_data),  32'h7E);
      ss_n = 1'b0;
      host_bits(8'h96, 8, 1'b0, 8'h00, mi);
      check_eq("t4_rx_data",  32'(rx_data),  32'h96);
      check_eq("t4_host_rd",  32'(mi),       32'hFF);
      check_eq("t4_rxv_one",  rxv_cnt - r0,  32'h1);
      deselect();

      // Write while full is ignored.
      write_buf(8'hAA);
      check_eq("t5_tx_ready", 32'(tx_ready), 32'h0);
      write_buf(8'h55);
      check_eq("t5_still_full", 32'(tx_ready), 32'h0);
      ss_n = 1'b0;
      host_bits(8'h00, 8, 1'b0, 8'h00, mi);
      check_eq("t5_host_rd",  32'(mi),       32'hAA);
      deselect();

      // Async reset mid-byte.
      write_buf(8'h3C);
      ss_n = 1'b0;
      host_bits(8'h11, 3, 1'b0, 8'h00, mi);
      reset_n = 1'b0;
      #1;
      check_reset_vals("t6_rst");
      ss_n = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("t6_buf_clr",  32'(tx_ready), 32'h1);
      write_buf(8'hC3);
      r0 = rxv_cnt;
      ss_n = 1'b0;
      host_bits(8'h42, 8, 1'b0, 8'h00, mi);
      check_eq("t6_host_rd",  32'(mi),       32'hC3);
      check_eq("t6_rx_data",  32'(rx_data),  32'h42);
      check_eq("t6_rxv_cnt",  rxv_cnt - r0,  32'h1);
      deselect();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule : tb_spi_dev
